syscall_input_port: RTL and testbench

- Operator-input device for the single-cycle MIPS core. It is the input counterpart of the syscall-driven LED/seven-segment output path.
- When the core executes a "read value" syscall, it asserts req. This block then stalls the PC while the operator enters an 8-digit hex word with debounced buttons.
- On commit it returns the word for one cycle so the core can write it to $v0 and advance.
- The edit buffer is exported so the top level can route it to the seven-segment driver during entry.

---
 rtl/syscall_input_port.sv | 146 ++++++++++++++
 tb/tb_syscall_input_port.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/syscall_input_port.sv
// Operator hex-word entry for the read-value syscall: stalls the core while
// the user edits eight nibbles with debounced buttons, then returns the word.
module syscall_input_port #(
    parameter int DATA_BITS       = 32,
    parameter int DIGITS          = 8,
    parameter int DEBOUNCE_CYCLES = 20
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req,
    input  logic                 btn_inc,
    input  logic                 btn_next,
    input  logic                 btn_enter,
    output logic                 stall,
    output logic                 valid,
    output logic [DATA_BITS-1:0] value,
    output logic [DATA_BITS-1:0] edit_buf,
    output logic [2:0]           digit_idx,
    output logic                 editing
);

    localparam int NUM_BTN = 3;
    localparam int CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int BTN_INC = 0;
    localparam int BTN_NXT = 1;
    localparam int BTN_ENT = 2;

    typedef enum logic [1:0] {
        IDLE,
        EDIT,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic [NUM_BTN-1:0] raw_btn;
    logic [NUM_BTN-1:0] sync_0, sync_1, db_level, btn_pulse;
    logic [CNT_W-1:0]   db_cnt [NUM_BTN];

    logic start_entry, do_commit, do_next, do_inc;

    assign raw_btn = {btn_enter, btn_next, btn_inc};

    // Synchronise, debounce, and turn each debounced rising edge into a pulse
    // that lines up with the cycle the debounced level goes high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_0    <= '0;
            sync_1    <= '0;
            db_level  <= '0;
            btn_pulse <= '0;
            for (int i = 0; i < NUM_BTN; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync_0    <= raw_btn;
            sync_1    <= sync_0;
            btn_pulse <= '0;
            for (int i = 0; i < NUM_BTN; i++) begin
                if (sync_1[i] != db_level[i]) begin
                    if (db_cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                        db_level[i]  <= sync_1[i];
                        db_cnt[i]    <= '0;
                        btn_pulse[i] <= sync_1[i];
                    end else begin
                        db_cnt[i] <= db_cnt[i] + CNT_W'(1);
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Abort beats every pulse; among pulses enter > next > inc.
    always_comb begin
        state_nxt   = state;
        start_entry = 1'b0;
        do_commit   = 1'b0;
        do_next     = 1'b0;
        do_inc      = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    state_nxt   = EDIT;
                    start_entry = 1'b1;
                end
            end
            EDIT: begin
                if (!req) begin
                    state_nxt = IDLE;
                end else if (btn_pulse[BTN_ENT]) begin
                    state_nxt = DONE;
                    do_commit = 1'b1;
                end else if (btn_pulse[BTN_NXT]) begin
                    do_next = 1'b1;
                end else if (btn_pulse[BTN_INC]) begin
                    do_inc = 1'b1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid     <= 1'b0;
            value     <= '0;
            edit_buf  <= '0;
            digit_idx <= '0;
        end else begin
            valid <= do_commit;
            if (start_entry) begin
                edit_buf  <= '0;
                digit_idx <= '0;
            end
            if (do_commit) begin
                value <= edit_buf;
            end
            if (do_next) begin
                digit_idx <= (digit_idx == 3'(DIGITS - 1)) ? 3'd0 : digit_idx + 3'd1;
            end
            // Nibble wraps on its own; no carry into the neighbour.
            if (do_inc) begin
                edit_buf[4*int'(digit_idx) +: 4] <= edit_buf[4*int'(digit_idx) +: 4] + 4'd1;
            end
        end
    end

    assign stall   = req & ~rst & (state != DONE);
    assign editing = (state == EDIT);

endmodule

// File: tb/tb_syscall_input_port.sv
// Self-checking bench for syscall_input_port: a spec-level reference model is
// compared every cycle, plus literal expectations for the directed scenarios.
module tb_syscall_input_port;

    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        btn_inc;
    logic        btn_next;
    logic        btn_enter;
    logic        stall;
    logic        valid;
    logic [31:0] value;
    logic [31:0] edit_buf;
    logic [2:0]  digit_idx;
    logic        editing;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    syscall_input_port #(
        .DATA_BITS      (32),
        .DIGITS         (8),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .btn_inc  (btn_inc),
        .btn_next (btn_next),
        .btn_enter(btn_enter),
        .stall    (stall),
        .valid    (valid),
        .value    (value),
        .edit_buf (edit_buf),
        .digit_idx(digit_idx),
        .editing  (editing)
    );

    // Reference model: phase of the syscall, the word being built, and for each
    // button the raw sample history (bit j = sample taken j edges ago).
    typedef enum int {M_IDLE, M_EDIT, M_DONE} mphase_t;

    mphase_t     m_phase;
    logic [31:0] m_value;
    logic [31:0] m_buf;
    int          m_idx;
    logic [15:0] m_hist [3];
    logic [2:0]  m_db;
    logic [2:0]  m_pulse;

    function automatic logic [31:0] nib_inc(input logic [31:0] w, input int i);
        logic [3:0] n;
        n = 4'((w >> (4 * i)) & 32'hF);
        n = n + 4'd1;
        return (w & ~(32'hF << (4 * i))) | (32'(n) << (4 * i));
    endfunction

    // The settled level lags the raw pin by two samples; it flips once the
    // last D of those lagged samples all disagree with it.
    function automatic logic window_flips(input logic [15:0] h, input logic db);
        for (int j = 2; j <= D + 1; j++) begin
            if (h[j] == db) return 1'b0;
        end
        return 1'b1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase <= M_IDLE;
            m_value <= '0;
            m_buf   <= '0;
            m_idx   <= 0;
            m_db    <= '0;
            m_pulse <= '0;
            for (int b = 0; b < 3; b++) m_hist[b] <= '0;
        end else begin
            case (m_phase)
                M_IDLE: if (req) begin
                    m_phase <= M_EDIT;
                    m_buf   <= '0;
                    m_idx   <= 0;
                end
                M_EDIT: begin
                    if (!req) m_phase <= M_IDLE;
                    else if (m_pulse[2]) begin
                        m_value <= m_buf;
                        m_phase <= M_DONE;
                    end
                    else if (m_pulse[1]) m_idx <= (m_idx + 1) % 8;
                    else if (m_pulse[0]) m_buf <= nib_inc(m_buf, m_idx);
                end
                default: m_phase <= M_IDLE;
            endcase
            for (int b = 0; b < 3; b++) begin
                m_hist[b]  <= {m_hist[b][14:0], (b == 0) ? btn_inc : (b == 1) ? btn_next : btn_enter};
                if (window_flips({m_hist[b][14:0], (b == 0) ? btn_inc : (b == 1) ? btn_next : btn_enter}, m_db[b])) begin
                    m_db[b]    <= ~m_db[b];
                    m_pulse[b] <= ~m_db[b];
                end else begin
                    m_pulse[b] <= 1'b0;
                end
            end
        end
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_total++;
        if (actual !== expected) begin
            n_bad++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        check_output("cyc_valid", 32'(valid), 32'(m_phase == M_DONE));
        check_output("cyc_value", value, m_value);
        check_output("cyc_edit_buf", edit_buf, m_buf);
        check_output("cyc_digit_idx", 32'(digit_idx), 32'(m_idx));
        check_output("cyc_editing", 32'(editing), 32'(m_phase == M_EDIT));
        check_output("cyc_stall", 32'(stall), 32'(req && !rst && m_phase != M_DONE));
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic apply_stimulus(input logic [2:0] mask, input int hold, input int settle);
        {btn_enter, btn_next, btn_inc} = mask;
        step(hold);
        {btn_enter, btn_next, btn_inc} = 3'b000;
        step(settle);
    endtask

    task automatic press(input logic [2:0] mask, input int times);
        for (int k = 0; k < times; k++) apply_stimulus(mask, D + 2, D + 4);
    endtask

    // Holds the given buttons until valid appears (bounded); leaves the bench
    // at the negedge of the DONE cycle so the caller can inspect it.
    task automatic commit_and_wait(input logic [2:0] mask, output logic seen);
        seen = 1'b0;
        {btn_enter, btn_next, btn_inc} = mask;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (valid === 1'b1) seen = 1'b1;
        end
        check_output("valid_seen", 32'(seen), 32'd1);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout actual=running required=finished");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic seen;
        int   vcount;

        rst = 1'b1;
        req = 1'b0;
        {btn_enter, btn_next, btn_inc} = 3'b000;
        step(2);
        req = 1'b1;
        #1 check_output("stall_in_reset", 32'(stall), 32'd0);
        req = 1'b0;
        step(1);
        rst = 1'b0;

        // Presses while idle are ignored.
        press(3'b001, 1);
        press(3'b100, 1);
        press(3'b010, 1);
        check_output("idle_edit_buf", edit_buf, 32'h0);
        check_output("idle_value", value, 32'h0);
        check_output("idle_valid", 32'(valid), 32'd0);

        // Basic entry.
        req = 1'b1;
        #1 check_output("stall_same_cycle", 32'(stall), 32'd1);
        check_output("editing_not_yet", 32'(editing), 32'd0);
        step(1);
        check_output("editing_next_cycle", 32'(editing), 32'd1);
        press(3'b001, 3);
        press(3'b010, 1);
        press(3'b001, 1);
        check_output("basic_edit_buf", edit_buf, 32'h13);
        check_output("basic_digit_idx", 32'(digit_idx), 32'd1);
        commit_and_wait(3'b100, seen);
        check_output("basic_value", value, 32'h13);
        check_output("basic_stall_done", 32'(stall), 32'd0);
        #1;
        req = 1'b0;
        {btn_enter, btn_next, btn_inc} = 3'b000;
        step(2);
        check_output("basic_idle_after", 32'(editing), 32'd0);
        step(D + 4);

        // Nibble wrap and index wrap.
        req = 1'b1;
        step(1);
        press(3'b001, 17);
        check_output("wrap_nibble", edit_buf, 32'h1);
        press(3'b010, 8);
        check_output("wrap_index", 32'(digit_idx), 32'd0);

        // Debounce: glitch, held press, long hold.
        apply_stimulus(3'b001, 2, D + 4);
        check_output("glitch_ignored", edit_buf, 32'h1);
        apply_stimulus(3'b001, 10, D + 4);
        check_output("hold10_once", edit_buf, 32'h2);
        apply_stimulus(3'b001, 40, D + 4);
        check_output("long_hold_no_repeat", edit_buf, 32'h3);

        // Enter and inc together: commit wins; req stays high for back-to-back.
        commit_and_wait(3'b101, seen);
        check_output("simul_value", value, 32'h3);
        #1;
        {btn_enter, btn_next, btn_inc} = 3'b000;
        step(3);
        check_output("b2b_editing", 32'(editing), 32'd1);
        check_output("b2b_cleared", edit_buf, 32'h0);
        step(D + 4);

        // Abort mid-edit.
        press(3'b001, 2);
        check_output("abort_pre_buf", edit_buf, 32'h2);
        req = 1'b0;
        step(1);
        check_output("abort_idle", 32'(editing), 32'd0);
        step(2);
        check_output("abort_buf_kept", edit_buf, 32'h2);
        check_output("abort_value_kept", value, 32'h3);
        press(3'b100, 1);
        check_output("abort_enter_ignored", value, 32'h3);

        // Build 0xABCD0000 then reset between edges.
        req = 1'b1;
        step(1);
        press(3'b010, 4);
        press(3'b001, 13);
        press(3'b010, 1);
        press(3'b001, 12);
        press(3'b010, 1);
        press(3'b001, 11);
        press(3'b010, 1);
        press(3'b001, 10);
        check_output("abcd_edit_buf", edit_buf, 32'hABCD0000);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_output("rst_valid", 32'(valid), 32'd0);
        check_output("rst_value", value, 32'h0);
        check_output("rst_edit_buf", edit_buf, 32'h0);
        check_output("rst_digit_idx", 32'(digit_idx), 32'd0);
        check_output("rst_editing", 32'(editing), 32'd0);
        check_output("rst_stall", 32'(stall), 32'd0);
        step(2);
        rst = 1'b0;
        req = 1'b0;
        vcount = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (valid === 1'b1) vcount++;
        end
        check_output("no_valid_after_reset", 32'(vcount), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
